// File: rtl/dec_pkg.sv
// Shared constants and helpers for the scanning active-low decoder.
package dec_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Dwell counter width: max(1, clog2(dwell)).
   function automatic int cnt_width(input int dwell);
      return (dwell <= 2) ? 1 : $clog2(dwell);
   endfunction

endpackage

// File: rtl/dec_n_low.sv
// Combinational N-to-2^N decoder, active-low one-cold output with enable.
module dec_n_low #(
   parameter int N = 4
) (
   input  logic             en,
   input  logic [N-1:0]     w,
   output logic [0:(2**N)-1] y
);

   // Drive only position w low while enabled; otherwise everything inactive.
   always_comb begin
      y = '1;
      if (en) y[w] = 1'b0;
   end

endmodule

// File: rtl/dec_scan_low.sv
// Registered active-low decoder with manual decode and auto-scan modes.
module dec_scan_low
   import dec_pkg::*;
#(
   parameter int N     = 4,
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic [N-1:0]      w,
   output logic [0:(2**N)-1] y,
   output logic [N-1:0]      idx,
   output logic              wrap
);

   localparam int            OUTS     = 2**N;
   localparam int            CW       = cnt_width(DWELL);
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [N-1:0]    idx_nxt;
   logic            wrap_nxt;
   logic [0:OUTS-1] y_nxt;

   // Next index/counter/wrap; disabled cycles hold idx and cnt so scan resumes.
   always_comb begin
      idx_nxt  = idx;
      cnt_nxt  = cnt;
      wrap_nxt = 1'b0;
      if (en) begin
         if (mode == MODE_MANUAL) begin
            idx_nxt = w;
            cnt_nxt = '0;
         end else if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            idx_nxt  = idx + 1'b1;
            wrap_nxt = (idx == '1);
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   // Decoding the next index keeps y aligned with idx in the same cycle.
   dec_n_low #(.N(N)) u_dec (
      .en (en),
      .w  (idx_nxt),
      .y  (y_nxt)
   );

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y    <= '1;
         idx  <= '0;
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         y    <= y_nxt;
         idx  <= idx_nxt;
         cnt  <= cnt_nxt;
         wrap <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_dec_scan_low.sv
// Bench for dec_scan_low: directed table, corner sequences, random vs model.
module tb_dec_scan_low;

   logic        clk = 1'b0;
   logic        rst_n, en, mode;
   logic [3:0]  w;
   logic [0:15] ya;
   logic [3:0]  idxa;
   logic        wrapa;
   logic [0:3]  yb;
   logic [1:0]  idxb;
   logic        wrapb;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // DUT A: N=4, DWELL=3.  DUT B: N=2, DWELL=1.  Both see the same stimulus.
   dec_scan_low #(.N(4), .DWELL(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .w(w),
      .y(ya), .idx(idxa), .wrap(wrapa)
   );

   dec_scan_low #(.N(2), .DWELL(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .w(w[1:0]),
      .y(yb), .idx(idxb), .wrap(wrapb)
   );

   // Reference model: current position, cycles already spent there in scan.
   int          m_pos[2];
   int          m_spent[2];
   bit          m_wrap[2];
   logic [15:0] m_y[2];
   bit          m_init = 1'b0;

   function automatic logic [15:0] sel_low(input int outs, input int pos);
      logic [15:0] all_ones;
      all_ones = 16'((32'd1 << outs) - 1);
      // y[0] is the MSB of the packed vector, so position pos sits at bit outs-1-pos.
      return all_ones & ~16'(32'd1 << (outs - 1 - pos));
   endfunction

   function automatic void model_step(input int d, input bit r, input bit e,
                                      input bit md, input int wv);
      int outs;
      int dwell;
      outs  = (d == 0) ? 16 : 4;
      dwell = (d == 0) ? 3 : 1;
      m_wrap[d] = 1'b0;
      if (!r) begin
         m_pos[d]   = 0;
         m_spent[d] = 0;
         m_y[d]     = 16'((32'd1 << outs) - 1);
      end else if (!e) begin
         m_y[d] = 16'((32'd1 << outs) - 1);
      end else if (!md) begin
         m_pos[d]   = wv % outs;
         m_spent[d] = 0;
         m_y[d]     = sel_low(outs, m_pos[d]);
      end else begin
         m_spent[d] = m_spent[d] + 1;
         if (m_spent[d] == dwell) begin
            m_spent[d] = 0;
            m_wrap[d]  = (m_pos[d] == outs - 1);
            m_pos[d]   = (m_pos[d] + 1) % outs;
         end
         m_y[d] = sel_low(outs, m_pos[d]);
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("model_ya",    ya,    m_y[0]);
      chk("model_idxa",  idxa,  m_pos[0]);
      chk("model_wrapa", wrapa, m_wrap[0]);
      chk("model_yb",    yb,    m_y[1] & 16'hF);
      chk("model_idxb",  idxb,  m_pos[1]);
      chk("model_wrapb", wrapb, m_wrap[1]);
   endtask

   // Apply inputs, confirm outputs stay put before the edge, then take one edge.
   task automatic tick(input bit r, input bit e, input bit md, input logic [3:0] wv);
      rst_n = r; en = e; mode = md; w = wv;
      #1;
      if (m_init) begin
         chk("pre_edge_ya",   ya,   m_y[0]);
         chk("pre_edge_idxa", idxa, m_pos[0]);
      end
      @(posedge clk);
      model_step(0, r, e, md, int'(wv));
      model_step(1, r, e, md, int'(wv));
      if (!r) m_init = 1'b1;
      #1;
   endtask

   typedef struct {
      bit          r, e, md;
      logic [3:0]  wv;
      logic [15:0] exp_y;
      logic [3:0]  exp_idx;
      bit          exp_wrap;
   } vec_t;

   vec_t vecs[12];

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 1'b1; w = '0;

      // Reset, manual decode, then scan across the 15 -> 0 wrap (DUT A, DWELL=3).
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'd0,  16'hFFFF, 4'd0,  1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'd7,  16'hFFFF, 4'd0,  1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd5,  16'hFBFF, 4'd5,  1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd0,  16'h7FFF, 4'd0,  1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd14, 16'hFFFD, 4'd14, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'd3,  16'hFFFD, 4'd14, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'd3,  16'hFFFD, 4'd14, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd3,  16'hFFFE, 4'd15, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd3,  16'hFFFE, 4'd15, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd3,  16'hFFFE, 4'd15, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 4'd3,  16'h7FFF, 4'd0,  1'b1};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 4'd3,  16'h7FFF, 4'd0,  1'b0};

      for (int i = 0; i < 12; i++) begin
         tick(vecs[i].r, vecs[i].e, vecs[i].md, vecs[i].wv);
         chk($sformatf("vec%0d_y", i),    ya,    vecs[i].exp_y);
         chk($sformatf("vec%0d_idx", i),  idxa,  vecs[i].exp_idx);
         chk($sformatf("vec%0d_wrap", i), wrapa, vecs[i].exp_wrap);
      end

      // Enable hold: one dwell cycle spent at 3, pause, then 2 more to reach 4.
      tick(1, 1, 0, 4'd3);
      tick(1, 1, 1, 4'd0);
      chk("hold_scan_idx", idxa, 4'd3);
      tick(1, 0, 1, 4'd0);
      chk("hold_off_y",   ya,    16'hFFFF);
      chk("hold_off_idx", idxa,  4'd3);
      chk("hold_off_wr",  wrapa, 1'b0);
      tick(1, 0, 1, 4'd0);
      chk("hold_off2_idx", idxa, 4'd3);
      tick(1, 1, 1, 4'd0);
      chk("resume1_idx", idxa, 4'd3);
      chk("resume1_y",   ya,   16'hEFFF);
      tick(1, 1, 1, 4'd0);
      chk("resume2_idx", idxa, 4'd4);
      chk("resume2_y",   ya,   16'hF7FF);

      // Mid-scan reset at idx 9, then scan restarts from 0 with full dwell counts.
      tick(1, 1, 0, 4'd9);
      chk("pre_rst_idx", idxa, 4'd9);
      tick(0, 1, 1, 4'd0);
      chk("mid_rst_y",   ya,   16'hFFFF);
      chk("mid_rst_idx", idxa, 4'd0);
      begin
         logic [3:0] exp_seq [6];
         exp_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
         for (int i = 0; i < 6; i++) begin
            tick(1, 1, 1, 4'd0);
            chk($sformatf("restart%0d_idx", i), idxa, exp_seq[i]);
            chk($sformatf("restart%0d_y", i),   ya,   sel_low(16, int'(exp_seq[i])));
         end
      end

      // Small config (DUT B, N=2, DWELL=1): preload 3, then advance every edge.
      tick(1, 1, 0, 4'd3);
      chk("small_pre_y", yb, 4'b1110);
      begin
         logic [3:0] exp_y [8];
         exp_y = '{4'b0111, 4'b1011, 4'b1101, 4'b1110,
                   4'b0111, 4'b1011, 4'b1101, 4'b1110};
         for (int i = 0; i < 8; i++) begin
            tick(1, 1, 1, 4'd0);
            chk($sformatf("small%0d_y", i),    yb,    exp_y[i]);
            chk($sformatf("small%0d_wrap", i), wrapb, (i % 4) == 0);
         end
      end

      // Randomised stimulus on both configurations against the model.
      for (int i = 0; i < 400; i++) begin
         bit r, e, md;
         r  = ($urandom_range(0, 39) != 0);
         e  = ($urandom_range(0, 9) != 0);
         md = ($urandom_range(0, 9) < 7);
         tick(r, e, md, 4'($urandom_range(0, 15)));
         chk_model();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
